// File: rtl/zstr_pkg.sv
// Shared definitions for the z stream source and drain: put status codes,
// source state encoding and a pointer-width helper.
package zstr_pkg;

  localparam int ZSTR_OK   = 0;
  localparam int ZSTR_FULL = 1;
  localparam int ZSTR_RST  = 2;

  typedef enum logic [1:0] {IDL, DLY, VLD} zstr_st_t;

  function automatic int ptrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/zstr_src_if.sv
// z stream handshake bundle: valid/bus travel downstream, ready travels upstream.
interface zstr_src_if #(parameter int BW = 1);

  logic          vld;
  logic [BW-1:0] bus;
  logic          rdy;

  modport master (output vld, output bus, input rdy);
  modport slave  (input vld, input bus, output rdy);

endinterface

// File: rtl/zstr_que.sv
// Entry queue for zstr_src: the put side is owned by the put task, the pop side
// by the clocked process, so the two never share a writer.
module zstr_que
  import zstr_pkg::*;
#(
  parameter int QL = 4,
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_pop,
  output logic [DW-1:0] o_head,
  output logic [DW-1:0] o_next,
  output logic [31:0]   o_cnt
);

  localparam int            PW   = ptrWidth(QL);
  localparam logic [PW-1:0] LAST = PW'(QL - 1);

  logic [DW-1:0] r_mem [QL];
  logic [PW-1:0] r_wrPtr  = '0;
  logic [31:0]   r_putTot = '0;
  logic [PW-1:0] r_rdPtr;
  logic [31:0]   r_popTot;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [31:0] occ();
    return r_putTot - r_popTot;
  endfunction

  assign o_cnt  = r_putTot - r_popTot;
  assign o_head = r_mem[r_rdPtr];
  assign o_next = r_mem[inc(r_rdPtr)];

  task automatic put(output logic ok, input logic [DW-1:0] data);
    if (r_putTot - r_popTot >= 32'(QL)) begin
      ok = 1'b0;
    end else begin
      r_mem[r_wrPtr] = data;
      r_wrPtr        = inc(r_wrPtr);
      r_putTot       = r_putTot + 32'd1;
      ok             = 1'b1;
    end
  endtask

  // Reset flushes by catching the read side up with the write side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_popTot <= r_putTot;
      r_rdPtr  <= r_wrPtr;
    end else if (i_pop) begin
      r_popTot <= r_popTot + 32'd1;
      r_rdPtr  <= inc(r_rdPtr);
    end
  end

endmodule

// File: rtl/zstr_src.sv
// z stream source: queued entries are presented on the stream after their
// programmed idle delay, one transfer per accepted valid/ready handshake.
module zstr_src
  import zstr_pkg::*;
#(
  parameter int            BW = 1,
  parameter logic [BW-1:0] XZ = 'x,
  parameter int            QL = 4,
  parameter int            TW = 8
) (
  input  logic clk,
  input  logic rst,
  zstr_src_if.master z
);

  localparam int DW = TW + BW;

  zstr_st_t      r_st, w_stNxt;
  logic [TW-1:0] r_dcnt, w_dcntNxt;
  logic [31:0]   r_trn;
  logic          w_pop, w_load;
  logic [DW-1:0] w_head, w_next, w_loadEnt;
  logic [31:0]   w_cnt;

  zstr_que #(.QL(QL), .DW(DW)) u_que (
    .clk    (clk),
    .rst    (rst),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_next (w_next),
    .o_cnt  (w_cnt)
  );

  task automatic put(output int sts, input logic [TW-1:0] dly, input logic [BW-1:0] bus);
    logic ok;
    if (rst) begin
      sts = ZSTR_RST;
    end else begin
      u_que.put(ok, {dly, bus});
      sts = ok ? ZSTR_OK : ZSTR_FULL;
    end
  endtask

  task automatic stat(output int cnt, output int trn);
    cnt = int'(u_que.occ());
    trn = int'(r_trn);
  endtask

  // On a transfer the entry behind the head is loaded in the same edge.
  always_comb begin
    w_stNxt   = r_st;
    w_dcntNxt = r_dcnt;
    w_pop     = 1'b0;
    w_load    = 1'b0;
    w_loadEnt = '0;
    case (r_st)
      IDL: begin
        if (w_cnt != 32'd0) begin
          w_load    = 1'b1;
          w_loadEnt = w_head;
        end
      end
      DLY: begin
        w_dcntNxt = r_dcnt - 1'b1;
        if (r_dcnt == TW'(1)) w_stNxt = VLD;
      end
      VLD: begin
        if (z.rdy) begin
          w_pop   = 1'b1;
          w_stNxt = IDL;
          if (w_cnt > 32'd1) begin
            w_load    = 1'b1;
            w_loadEnt = w_next;
          end
        end
      end
      default: w_stNxt = IDL;
    endcase
    if (w_load) begin
      if (w_loadEnt[DW-1:BW] == '0) begin
        w_stNxt = VLD;
      end else begin
        w_stNxt   = DLY;
        w_dcntNxt = w_loadEnt[DW-1:BW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st   <= IDL;
      r_dcnt <= '0;
      r_trn  <= '0;
    end else begin
      r_st   <= w_stNxt;
      r_dcnt <= w_dcntNxt;
      if (w_pop) r_trn <= r_trn + 32'd1;
    end
  end

  assign z.vld = (r_st == VLD);
  assign z.bus = (r_st == VLD) ? w_head[BW-1:0] : XZ;

endmodule

// File: doc/zstr_src.md
# zstr_src

Testbench stream source for the z stream protocol: drives `z_vld`/`z_bus` into a device under test or directly into `zstr_drn`. The bench queues entries through a task call; each entry carries a bus value and a pre-transfer delay in idle cycles. The block is the upstream partner of the stream drain and uses the same valid/ready rules and idle-state convention.

## Interface

**Parameters**
- `BW`, 1, bus width.
- `XZ`, `1'bx`, value driven on `z_bus` while `z_vld` is low.
- `QL`, 4, queue length in entries (any value ≥1; not restricted to a power of 2).
- `TW`, 8, delay field width; maximum delay is 2^TW−1 cycles.

**Ports**
- `clk`, input, 1, system clock.
- `rst`, input, 1, reset. Asynchronous, active-high.
- `z_vld`, output, 1, transfer valid.
- `z_bus`, output, BW, grouped bus signals.
- `z_rdy`, input, 1, transfer ready.

**Tasks**
- `put (output int sts, input logic [TW-1:0] dly, input logic [BW-1:0] bus)`: enqueue one entry.
- `stat (output int cnt, output int trn)`: return current occupancy and total completed transfers.

## Operation

- Status codes:
  - `ZSTR_OK`=0: entry accepted.
  - `ZSTR_FULL`=1: queue holds QL entries; entry dropped, no state change.
  - `ZSTR_RST`=2: `rst` is high; entry dropped.
- Occupancy is `put_tot − pop_tot`.
  - `put_tot` and the write pointer are written only by `put`.
  - `pop_tot` and the read pointer are written only by the clocked process.
  - This split means no variable has two writers, so a `put` in the same time step as a pop is race-free.
- Pointers wrap modulo QL.
- States:
  - IDL: queue empty. `z_vld`=0, `z_bus`=XZ.
  - DLY: head entry loaded, counting down. `z_vld`=0, `z_bus`=XZ.
  - VLD: `z_vld`=1, `z_bus`=head data.
- Head load happens at a posedge when either:
  - (IDL and occupancy>0), or
  - (VLD and transfer and occupancy>1).
  - On load: if `dly`==0, go to VLD; else go to DLY with `dcnt`=`dly`.
- DLY: `dcnt` decrements each posedge. At the posedge where `dcnt`==1, go to VLD.
- Transfer = `z_vld & z_rdy`, sampled at posedge. On transfer:
  - pop the head;
  - `trn` increments;
  - next state is VLD, DLY or IDL according to the head-load rule.
- `z_rdy` is ignored while `z_vld`=0.
- Reset (asynchronous, effective immediately, including mid-transfer or mid-delay):
  - state IDL, `z_vld`=0, `z_bus`=XZ;
  - queue flushed (`pop_tot`←`put_tot`, read pointer←write pointer);
  - `dcnt`=0, `trn`=0.
  - Entries in flight are discarded without a transfer being counted.

## Timing

- Latency: entry put between edges k−1 and k with `dly`=N and queue otherwise empty:
  - `z_vld` is low for N full cycles after edge k;
  - it rises after edge k+N and is high from edge k+N to the accepting edge.
- Back-to-back: `dly`=0 entries already queued produce one transfer per cycle while `z_rdy`=1.
- Stability: while `z_vld`=1 and `z_rdy`=0, `z_vld` and `z_bus` are held unchanged across edges. `z_vld` never drops without a transfer, except on reset.
- Queue full: `put` is rejected while occupancy==QL. A pop at the current edge frees a slot only for `put` calls after that edge.
- Delay bound: `dly`=2^TW−1 gives exactly 2^TW−1 idle cycles; no overflow.

## Structure

- Package `zstr_pkg` holds:
  - status constants `ZSTR_OK`, `ZSTR_FULL`, `ZSTR_RST`;
  - state typedef `zstr_st_t` {IDL, DLY, VLD}.
- `zstr_drn` later adopts the same status constants.
- One natural sub-module, `zstr_que`: a parameterized entry queue of width TW+BW providing `put`, head peek and pop, with a split put/pop counter.
- The state machine and delay counter stay in `zstr_src`.

## Test plan

- After reset with no puts, run 20 cycles → `z_vld`=0 and `z_bus`=XZ throughout; `stat` returns cnt=0, trn=0.
- Put (dly=3, bus=A), `z_rdy`=1 → `z_vld` low 3 cycles, high for 1 cycle with `z_bus`=A; trn=1.
- With QL=4, put 4 entries with dly=0 then a 5th → 5th returns `ZSTR_FULL`. With `z_rdy`=1 → 4 consecutive transfers in input order.
- Put (0,A),(2,B), toggle `z_rdy` 0,0,1 → A held stable for 2 cycles, then transfer A, 2 idle cycles, then B valid.
- Put 3 entries, assert `rst` asynchronously mid-DLY for 2 cycles; `put` during `rst` → `ZSTR_RST`. `z_vld` drops without waiting for a clock edge; after release, cnt=0, trn=0 and no stale data appears.
- QL=3, dly=0, 10 puts interleaved with pops at the same edges → all 10 delivered in order, no loss or duplication across pointer wrap.
